// File: rtl/game_pkg.sv
// Shared types and helpers for the maze game round controller.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_PLAY,
        S_DIED,
        S_CLEARED,
        S_WON,
        S_LOST
    } state_t;

    localparam logic [1:0] BANNER_NONE    = 2'd0;
    localparam logic [1:0] BANNER_DIED    = 2'd1;
    localparam logic [1:0] BANNER_CLEARED = 2'd2;
    localparam logic [1:0] BANNER_FINAL   = 2'd3;

    // Level index width; a single-level game still gets a 1-bit field.
    function automatic int level_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_sequencer_sec_tick.sv
// One-second tick generator: pulses tick for one cycle every TICK_DIV cycles.
module sec_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: level loading, countdown, lives and win/lose flow.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 4,
    parameter int LIVES       = 3,
    parameter int TICK_DIV    = 50_000_000,
    parameter int LEVEL_TIME  = 60,
    parameter int BANNER_SECS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_button,
    input  logic                             gameover,
    input  logic                             complete,
    input  logic                             load_done,
    output logic                             load_req,
    output logic                             round_start,
    output logic                             play,
    output logic [level_w(NUM_LEVELS)-1:0]   level,
    output logic [2:0]                       lives,
    output logic [6:0]                       time_left,
    output logic [1:0]                       banner,
    output logic                             win
);

    localparam int LW = level_w(NUM_LEVELS);
    localparam int BW = (BANNER_SECS > 1) ? $clog2(BANNER_SECS) : 1;

    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
    localparam logic [6:0]    TIME_INIT  = 7'(LEVEL_TIME);
    localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [BW-1:0] LAST_SEC   = BW'(BANNER_SECS - 1);

    if ((LIVES < 1) || (LIVES > 7)) begin : g_lives_check
        $error("game_sequencer: LIVES must be in 1..7");
    end

    state_t        state, state_n;
    logic [LW-1:0] level_n;
    logic [2:0]    lives_n;
    logic [6:0]    time_n;
    logic [BW-1:0] bsec, bsec_n;
    logic          start_prev;
    logic          start_edge;
    logic          tick;
    logic          tick_clear;

    // History follows the button even in reset, so a held button never looks like a press.
    always_ff @(posedge clk) begin
        start_prev <= start_button;
    end

    assign start_edge = start_button & ~start_prev;

    sec_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            level     <= '0;
            lives     <= '0;
            time_left <= '0;
            bsec      <= '0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            lives     <= lives_n;
            time_left <= time_n;
            bsec      <= bsec_n;
        end
    end

    always_comb begin
        state_n    = state;
        level_n    = level;
        lives_n    = lives;
        time_n     = time_left;
        bsec_n     = bsec;
        tick_clear = 1'b0;
        case (state)
            S_IDLE, S_WON, S_LOST: begin
                if (start_edge) begin
                    state_n = S_LOAD;
                    level_n = '0;
                    lives_n = LIVES_INIT;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    state_n    = S_ARM;
                    time_n     = TIME_INIT;
                    tick_clear = 1'b1;
                end
            end
            // The detector still shows the previous round's result here.
            S_ARM: state_n = S_PLAY;
            S_PLAY: begin
                if (gameover && complete) begin
                    state_n    = S_CLEARED;
                    bsec_n     = '0;
                    tick_clear = 1'b1;
                end else if (gameover || (tick && (time_left <= 7'd1))) begin
                    if (!gameover) begin
                        time_n = '0;
                    end
                    lives_n = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                    // Last life lost skips the death banner.
                    if (lives <= 3'd1) begin
                        state_n = S_LOST;
                    end else begin
                        state_n    = S_DIED;
                        bsec_n     = '0;
                        tick_clear = 1'b1;
                    end
                end else if (tick) begin
                    time_n = time_left - 7'd1;
                end
            end
            S_DIED: begin
                if (tick) begin
                    if (bsec == LAST_SEC) begin
                        state_n = S_LOAD;
                    end else begin
                        bsec_n = bsec + BW'(1);
                    end
                end
            end
            S_CLEARED: begin
                if (tick) begin
                    if (bsec != LAST_SEC) begin
                        bsec_n = bsec + BW'(1);
                    end else if (level == LAST_LEVEL) begin
                        state_n = S_WON;
                    end else begin
                        level_n = level + LW'(1);
                        state_n = S_LOAD;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign load_req    = (state == S_LOAD);
    assign round_start = (state == S_ARM);
    assign play        = (state == S_PLAY);
    assign win         = (state == S_WON);

    always_comb begin
        banner = BANNER_NONE;
        case (state)
            S_DIED:       banner = BANNER_DIED;
            S_CLEARED:    banner = BANNER_CLEARED;
            S_WON, S_LOST: banner = BANNER_FINAL;
            default:      banner = BANNER_NONE;
        endcase
    end

endmodule
